// File: rtl/exception_controller_pkg.sv
// Shared constants for the CP0 exception sequencer: ExcCodes, register field
// positions, handler vector and the sequencer state encoding.
package exception_controller_pkg;

    localparam logic [31:0] EXC_VECTOR = 32'h0000_0008;

    localparam logic [4:0] EXC_INT = 5'b00000;
    localparam logic [4:0] EXC_SYS = 5'b01000;
    localparam logic [4:0] EXC_BP  = 5'b01001;
    localparam logic [4:0] EXC_RI  = 5'b01010;
    localparam logic [4:0] EXC_OV  = 5'b01100;

    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_IM_LSB = 10;
    localparam int STATUS_IM_MSB = 15;
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_EXC_MSB = 6;
    localparam int CAUSE_IP_LSB  = 10;
    localparam int CAUSE_IP_MSB  = 15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAVE,
        ST_VECTOR,
        ST_RESTORE,
        ST_RETURN
    } state_t;

endpackage

// File: rtl/exception_controller_int_sync.sv
// Two-flop synchronizer for the external interrupt lines IP[7:2].
module int_sync #(
    parameter int WIDTH = 6
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/exception_controller.sv
// CP0 exception/ERET sequencer: composes Cause/Status/EPC writes and redirects the PC.
// state    | meaning
// IDLE     | waiting for exception, interrupt or eret
// SAVE     | Cause/Status/EPC strobes issued
// VECTOR   | redirect to handler vector
// RESTORE  | Status write clearing EXL, setting IE
// RETURN   | redirect to EPC
import exception_controller_pkg::*;

module exception_controller (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [5:0]  i_int_req,
    input  logic        i_exc_syscall,
    input  logic        i_exc_break,
    input  logic        i_exc_ri,
    input  logic        i_exc_ov,
    input  logic        i_eret,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_next_pc,
    input  logic [31:0] i_cause_read_data,
    input  logic [31:0] i_status_read_data,
    input  logic [31:0] i_epc_read_data,
    output logic        o_cause_write,
    output logic        o_status_write,
    output logic        o_epc_write,
    output logic [31:0] o_cause_write_data,
    output logic [31:0] o_status_write_data,
    output logic [31:0] o_epc_write_data,
    output logic        o_stall,
    output logic        o_redirect,
    output logic [31:0] o_redirect_target
);

    state_t      r_state;
    state_t      w_state_next;
    logic [5:0]  w_ip_sync;
    logic        w_exc_any;
    logic        w_int_pend;
    logic [4:0]  w_exccode;
    logic [31:0] w_epc_sel;

    logic        w_cause_write, w_status_write, w_epc_write, w_stall, w_redirect;
    logic [31:0] w_cause_data, w_status_data, w_epc_data, w_target;

    logic        r_cause_write, r_status_write, r_epc_write, r_stall, r_redirect;
    logic [31:0] r_cause_data, r_status_data, r_epc_data, r_target;

    int_sync #(.WIDTH(6)) u_int_sync (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_async (i_int_req),
        .o_sync  (w_ip_sync)
    );

    assign w_exc_any  = i_exc_ov | i_exc_ri | i_exc_syscall | i_exc_break;
    assign w_int_pend = (|(w_ip_sync & i_status_read_data[STATUS_IM_MSB:STATUS_IM_LSB]))
                        & i_status_read_data[STATUS_IE] & ~i_status_read_data[STATUS_EXL];
    assign w_epc_sel  = w_exc_any ? i_pc : i_next_pc;

    always_comb begin
        w_exccode = EXC_INT;
        if (i_exc_ov)           w_exccode = EXC_OV;
        else if (i_exc_ri)      w_exccode = EXC_RI;
        else if (i_exc_syscall) w_exccode = EXC_SYS;
        else if (i_exc_break)   w_exccode = EXC_BP;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_exc_any || w_int_pend) w_state_next = ST_SAVE;
                else if (i_eret)             w_state_next = ST_RESTORE;
            end
            ST_SAVE:    w_state_next = ST_VECTOR;
            ST_VECTOR:  w_state_next = ST_IDLE;
            ST_RESTORE: w_state_next = ST_RETURN;
            ST_RETURN:  w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered; SAVE is only
    // entered from IDLE, so the latched event data is captured here.
    always_comb begin
        w_cause_write  = 1'b0;
        w_status_write = 1'b0;
        w_epc_write    = 1'b0;
        w_redirect     = 1'b0;
        w_cause_data   = '0;
        w_status_data  = '0;
        w_epc_data     = '0;
        w_target       = '0;
        w_stall        = (w_state_next != ST_IDLE);
        case (w_state_next)
            ST_SAVE: begin
                w_cause_write  = 1'b1;
                w_status_write = 1'b1;
                w_epc_write    = 1'b1;
                w_cause_data   = {i_cause_read_data[31:16], w_ip_sync,
                                  i_cause_read_data[9:7], w_exccode,
                                  i_cause_read_data[1:0]};
                w_status_data  = {i_status_read_data[31:2], 1'b1, 1'b0};
                w_epc_data     = w_epc_sel;
            end
            ST_RESTORE: begin
                w_status_write = 1'b1;
                w_status_data  = {i_status_read_data[31:2], 1'b0, 1'b1};
            end
            ST_VECTOR: begin
                w_redirect = 1'b1;
                w_target   = EXC_VECTOR;
            end
            ST_RETURN: begin
                w_redirect = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cause_write  <= 1'b0;
            r_status_write <= 1'b0;
            r_epc_write    <= 1'b0;
            r_stall        <= 1'b0;
            r_redirect     <= 1'b0;
            r_cause_data   <= '0;
            r_status_data  <= '0;
            r_epc_data     <= '0;
            r_target       <= '0;
        end else begin
            r_cause_write  <= w_cause_write;
            r_status_write <= w_status_write;
            r_epc_write    <= w_epc_write;
            r_stall        <= w_stall;
            r_redirect     <= w_redirect;
            r_cause_data   <= w_cause_data;
            r_status_data  <= w_status_data;
            r_epc_data     <= w_epc_data;
            r_target       <= w_target;
        end
    end

    assign o_cause_write       = r_cause_write;
    assign o_status_write      = r_status_write;
    assign o_epc_write         = r_epc_write;
    assign o_cause_write_data  = r_cause_data;
    assign o_status_write_data = r_status_data;
    assign o_epc_write_data    = r_epc_data;
    assign o_stall             = r_stall;
    assign o_redirect          = r_redirect;
    // EPC is read live in RETURN since CP0 may have just been updated.
    assign o_redirect_target   = (r_state == ST_RETURN) ? i_epc_read_data : r_target;

endmodule

// File: tb/tb_exception_controller.sv
// Bench for exception_controller: a transaction-level model plays CP0 and
// predicts every cycle's outputs; directed scenarios add literal checks.
module tb_exception_controller;

    localparam int K_IDLE = 0, K_SAVE = 1, K_VEC = 2, K_RST = 3, K_RET = 4;

    typedef struct {
        int          kind;
        logic [31:0] cause_d;
        logic [31:0] status_d;
        logic [31:0] epc_d;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  int_req = '0;
    logic        exc_syscall = 0, exc_break = 0, exc_ri = 0, exc_ov = 0, eret = 0;
    logic [31:0] pc = '0, next_pc = '0;
    logic [31:0] cp_cause = 32'h0, cp_status = 32'h0000_FC01, cp_epc = 32'h0;

    logic        cause_write, status_write, epc_write, stall, redirect;
    logic [31:0] cause_wd, status_wd, epc_wd, redirect_target;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    exception_controller dut (
        .i_clock             (clk),
        .i_reset             (rst),
        .i_int_req           (int_req),
        .i_exc_syscall       (exc_syscall),
        .i_exc_break         (exc_break),
        .i_exc_ri            (exc_ri),
        .i_exc_ov            (exc_ov),
        .i_eret              (eret),
        .i_pc                (pc),
        .i_next_pc           (next_pc),
        .i_cause_read_data   (cp_cause),
        .i_status_read_data  (cp_status),
        .i_epc_read_data     (cp_epc),
        .o_cause_write       (cause_write),
        .o_status_write      (status_write),
        .o_epc_write         (epc_write),
        .o_cause_write_data  (cause_wd),
        .o_status_write_data (status_wd),
        .o_epc_write_data    (epc_wd),
        .o_stall             (stall),
        .o_redirect          (redirect),
        .o_redirect_target   (redirect_target)
    );

    // ---------------- behavioural model ----------------
    rec_t        q[$];
    rec_t        cur = '{K_IDLE, 32'h0, 32'h0, 32'h0};
    rec_t        tmp;
    logic [5:0]  h1 = '0, h2 = '0, ips;
    int          prev_kind, code;
    bit          m_exc, m_irq;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            cur = '{K_IDLE, 32'h0, 32'h0, 32'h0};
            h1 = '0;
            h2 = '0;
        end else begin
            ips = h2;
            h2 = h1;
            h1 = int_req;
            prev_kind = cur.kind;
            cur = '{K_IDLE, 32'h0, 32'h0, 32'h0};
            if (q.size() > 0) begin
                cur = q.pop_front();
            end else if (prev_kind == K_IDLE) begin
                m_exc = exc_ov || exc_ri || exc_syscall || exc_break;
                m_irq = ((ips & cp_status[15:10]) != 6'd0) && cp_status[0] && !cp_status[1];
                if (m_exc || m_irq) begin
                    code = exc_ov ? 12 : exc_ri ? 10 : exc_syscall ? 8 : exc_break ? 9 : 0;
                    cur.kind     = K_SAVE;
                    cur.cause_d  = (cp_cause & ~32'h0000_FC7C) | ({26'd0, ips} << 10)
                                   | (32'(code) << 2);
                    cur.status_d = (cp_status & ~32'h3) | 32'h2;
                    cur.epc_d    = m_exc ? pc : next_pc;
                    tmp = '{K_VEC, 32'h0, 32'h0, 32'h0};
                    q.push_back(tmp);
                end else if (eret) begin
                    cur.kind     = K_RST;
                    cur.status_d = (cp_status & ~32'h3) | 32'h1;
                    tmp = '{K_RET, 32'h0, 32'h0, 32'h0};
                    q.push_back(tmp);
                end
            end
        end
    end

    // ------------- compare process + CP0 emulation -------------
    int          n_cause_wr = 0, n_status_wr = 0, n_epc_wr = 0, n_redirect = 0;
    logic [31:0] last_target = '0;
    int          st_req = 0, st_ack = 0;
    logic [31:0] st_val = '0;
    int          pin_req = 0, pin_ack = 0;
    string       pin_nm = "";
    logic [31:0] pin_got = '0, pin_exp = '0;
    logic        e_cw, e_sw, e_ew, e_stall, e_redir;
    logic [31:0] e_cd, e_sd, e_ed, e_tgt;

    always @(negedge clk) begin
        e_cw    = (cur.kind == K_SAVE);
        e_ew    = (cur.kind == K_SAVE);
        e_sw    = (cur.kind == K_SAVE) || (cur.kind == K_RST);
        e_cd    = e_cw ? cur.cause_d : 32'h0;
        e_sd    = e_sw ? cur.status_d : 32'h0;
        e_ed    = e_ew ? cur.epc_d : 32'h0;
        e_stall = (cur.kind != K_IDLE);
        e_redir = (cur.kind == K_VEC) || (cur.kind == K_RET);
        e_tgt   = (cur.kind == K_VEC) ? 32'h0000_0008 : (cur.kind == K_RET) ? cp_epc : 32'h0;
        total++;
        if ({cause_write, status_write, epc_write, stall, redirect} !== {e_cw, e_sw, e_ew, e_stall, e_redir}
            || cause_wd !== e_cd || status_wd !== e_sd || epc_wd !== e_ed || redirect_target !== e_tgt) begin
            bad++;
            $display("FAIL cycle t=%0t got cw/sw/ew/stall/redir=%b%b%b%b%b cd=%h sd=%h ed=%h tgt=%h exp %b%b%b%b%b cd=%h sd=%h ed=%h tgt=%h",
                     $time, cause_write, status_write, epc_write, stall, redirect,
                     cause_wd, status_wd, epc_wd, redirect_target,
                     e_cw, e_sw, e_ew, e_stall, e_redir, e_cd, e_sd, e_ed, e_tgt);
        end
        if (cause_write === 1'b1)  begin cp_cause  = cause_wd;  n_cause_wr++;  end
        if (status_write === 1'b1) begin cp_status = status_wd; n_status_wr++; end
        if (epc_write === 1'b1)    begin cp_epc    = epc_wd;    n_epc_wr++;    end
        if (redirect === 1'b1)     begin last_target = redirect_target; n_redirect++; end
        if (st_req != st_ack) begin
            st_ack = st_req;
            cp_status = st_val;
        end
        if (pin_req != pin_ack) begin
            pin_ack = pin_req;
            total++;
            if (pin_got !== pin_exp) begin
                bad++;
                $display("FAIL %s got=%h exp=%h", pin_nm, pin_got, pin_exp);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pin(input string nm, input logic [31:0] got, input logic [31:0] exp);
        pin_nm  = nm;
        pin_got = got;
        pin_exp = exp;
        pin_req++;
        @(negedge clk);
        #1;
    endtask

    task automatic set_status(input logic [31:0] v);
        st_val = v;
        st_req++;
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] code_of(input logic [31:0] c);
        return {27'd0, c[6:2]};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tick(3);
        rst = 1'b0;
        tick(2);
        pin("reset_ctrl", {27'd0, cause_write, status_write, epc_write, stall, redirect}, 32'h0);

        // overflow
        exc_ov = 1; pc = 32'h0000_0100; next_pc = 32'h0000_0104;
        tick(1);
        exc_ov = 0;
        tick(4);
        pin("ov_code",   code_of(cp_cause), 32'h0000_000C);
        pin("ov_epc",    cp_epc,            32'h0000_0100);
        pin("ov_status", cp_status,         32'h0000_FC02);
        pin("ov_target", last_target,       32'h0000_0008);

        // syscall + break together
        exc_syscall = 1; exc_break = 1; pc = 32'h0000_0180;
        tick(1);
        exc_syscall = 0; exc_break = 0;
        tick(5);
        pin("sys_code",  code_of(cp_cause), 32'h0000_0008);
        pin("sys_nsave", n_cause_wr,        32'd2);
        pin("sys_nredir", n_redirect,       32'd2);

        // interrupt with IE=1
        set_status(32'h0000_FC01);
        int_req = 6'b000001; pc = 32'h0000_0300; next_pc = 32'h0000_0204;
        tick(6);
        int_req = 6'b0;
        tick(2);
        pin("irq_code", code_of(cp_cause),          32'h0);
        pin("irq_ip",   {26'd0, cp_cause[15:10]},   32'h1);
        pin("irq_epc",  cp_epc,                     32'h0000_0204);
        pin("irq_nsave", n_cause_wr,                32'd3);

        // interrupt with IE=0
        set_status(32'h0000_FC00);
        int_req = 6'b000001;
        tick(8);
        pin("irq_masked_nsave", n_cause_wr, 32'd3);
        int_req = 6'b0;
        tick(4);

        // eret
        set_status(32'h0000_FC02);
        eret = 1;
        tick(1);
        eret = 0;
        tick(4);
        pin("eret_status", cp_status,   32'h0000_FC01);
        pin("eret_target", last_target, 32'h0000_0204);
        pin("eret_ncause", n_cause_wr,  32'd3);
        pin("eret_nepc",   n_epc_wr,    32'd3);

        // eret and exc_ri together
        eret = 1; exc_ri = 1; pc = 32'h0000_0400;
        tick(1);
        eret = 0; exc_ri = 0;
        tick(5);
        pin("ri_code",    code_of(cp_cause), 32'h0000_000A);
        pin("ri_epc",     cp_epc,            32'h0000_0400);
        pin("ri_status",  cp_status,         32'h0000_FC02);
        pin("ri_target",  last_target,       32'h0000_0008);
        pin("ri_nstatus", n_status_wr,       32'd5);

        // reset during SAVE
        exc_ov = 1; pc = 32'h0000_0500;
        tick(1);
        exc_ov = 0;
        rst = 1;
        #1;
        pin("rst_ctrl", {27'd0, cause_write, status_write, epc_write, stall, redirect}, 32'h0);
        pin("rst_data", cause_wd | status_wd | epc_wd | redirect_target, 32'h0);
        tick(1);
        rst = 0;
        tick(8);
        pin("rst_ncause", n_cause_wr, 32'd4);
        pin("rst_epc",    cp_epc,     32'h0000_0400);

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exception_controller.md
# exception_controller

Sequencing block that drives the CP0 register file's write ports. It detects synchronous exceptions (syscall, break, reserved instruction, overflow), ERET, and masked external interrupts. For each event it composes the Cause/Status/EPC write words, then redirects the PC to the handler vector or back to EPC. It sits between decode/execute and CP0, and stalls the pipeline while a sequence is in flight.

## Interface
- EXC_VECTOR, 32'h0000_0008, handler entry address driven on redirect
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE and output reset values
- int_req  in  6  external interrupt lines IP[7:2], asynchronous level
- exc_syscall, exc_break, exc_ri, exc_ov  in  1 each  synchronous exception requests; held while stall=1
- eret  in  1  ERET request; held while stall=1
- pc  in  32  address of the current (faulting) instruction
- next_pc  in  32  address of the next instruction to execute
- Cause_read_data, Status_read_data, EPC_read_data  in  32 each  current CP0 contents
- Cause_write, Status_write, EPC_write  out  1 each  CP0 write strobes
- Cause_write_data, Status_write_data, EPC_write_data  out  32 each  CP0 write words
- stall  out  1  pipeline hold; high in every non-IDLE state
- redirect  out  1  one-cycle PC load pulse
- redirect_target  out  32  PC load value, valid while redirect=1

## Operation
- Register fields: Status IE=bit0, EXL=bit1, IM[7:2]=bits15:10; Cause ExcCode=bits6:2, IP[7:2]=bits15:10.
- ExcCode values: interrupt 5'b00000, syscall 5'b01000, break 5'b01001, RI 5'b01010, overflow 5'b01100.
- int_req passes through a 2-flop synchronizer to give ip_sync.
- An interrupt is pending when (ip_sync & Status[15:10]) != 0 and IE=1 and EXL=0.
- Priority in IDLE, highest first: exc_ov > exc_ri > exc_syscall > exc_break > pending interrupt > eret.
- The selected event, its ExcCode, ip_sync and the EPC value are latched on leaving IDLE. EPC value is pc for synchronous exceptions and next_pc for interrupts.
- States:
  - IDLE: on exception or interrupt go to SAVE; on eret alone go to RESTORE; otherwise stay.
  - SAVE: assert all three strobes.
    - Cause_write_data = {Cause[31:16], ip_latched, Cause[9:7], exccode, Cause[1:0]}.
    - Status_write_data = {Status[31:2], 1'b1, 1'b0}, i.e. EXL set and IE cleared.
    - EPC_write_data = the latched EPC value.
    - Go to VECTOR.
  - VECTOR: redirect=1, redirect_target=EXC_VECTOR; go to IDLE.
  - RESTORE: Status_write=1, Status_write_data = {Status[31:2], 1'b0, 1'b1}; go to RETURN.
  - RETURN: redirect=1, redirect_target=EPC_read_data (already updated by CP0); go to IDLE.
- Requests arriving in non-IDLE states are ignored. Requesters hold them under stall, so they are re-evaluated on return to IDLE.
- Simultaneous exception and eret: the exception wins and eret is dropped.
- Reset mid-sequence aborts immediately. No partial write is issued after reset deasserts.

## Timing
- Reset values: all strobes 0, all write data 32'h0, stall 0, redirect 0, redirect_target 32'h0, synchronizer flops 0, state IDLE.
- Synchronous exception sampled in IDLE at edge N:
  - cycle N+1 is SAVE (strobes high for exactly one cycle);
  - N+2 is VECTOR (redirect pulse);
  - N+3 is IDLE.
- stall is high during N+1..N+2.
- Interrupt: 2 extra cycles of synchronizer latency before it is visible in IDLE.
- ERET: RESTORE at N+1, RETURN at N+2.
- CP0 captures writes on the falling edge inside SAVE/RESTORE, so read data is updated before the following rising edge.
- Outputs are registered, with no combinational input-to-output paths except redirect_target in RETURN (EPC_read_data).

## Structure
- Shared package: ExcCode constants, Status/Cause bit-position constants, state enum (IDLE, SAVE, VECTOR, RESTORE, RETURN).
- One sub-module: int_sync, a 6-bit two-flop synchronizer with asynchronous reset.
- Total RTL size is roughly 150-250 lines.

## Test plan
- Reset with Status=32'h0000_FC01; pulse exc_ov with pc=32'h0000_0100 -> SAVE writes Cause ExcCode 01100, EPC 32'h0000_0100, Status 32'h0000_FC02; VECTOR redirects to 32'h0000_0008.
- exc_syscall and exc_break asserted together -> ExcCode 01000; exactly one SAVE and one VECTOR.
- int_req=6'b000001, IM all ones, IE=1, next_pc=32'h0000_0204 -> after 2 sync cycles, ExcCode 00000, Cause[15:10]=000001, EPC 32'h0000_0204. Repeat with IE=0 -> no response.
- eret with EPC=32'h0000_0204, Status=32'h0000_FC02 -> RESTORE writes 32'h0000_FC01; RETURN redirects to 32'h0000_0204; no Cause/EPC strobe.
- eret and exc_ri in the same cycle -> exception sequence only, ExcCode 01010.
- Assert reset during SAVE -> all outputs zero immediately; after release, no strobes until a new request arrives.
